// File: rtl/layer_scheduler.sv
// Sequences one shared neuron datapath over every output of a fully-connected layer:
// latch the input vector, then fetch/compute/emit one neuron result at a time.
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// FETCH | weight/bias row read issued for neuron idx
// MAC   | row data on the neuron inputs, neuron registers at end of cycle
// OUT   | result presented on out_data until out_ready
// DONE  | one-cycle layer_done pulse, then back to IDLE
module layer_scheduler #(
  parameter int LAYER_DATA_WIDTH = 16,
  parameter int NEURON_WIDTH     = 8,
  parameter int NUM_NEURONS      = 16,
  parameter int IDX_W            = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [NEURON_WIDTH*LAYER_DATA_WIDTH-1:0] in_data,
  input  logic                                     in_act,
  input  logic                                     abort,
  output logic                                     wmem_rd_en,
  output logic [IDX_W-1:0]                         wmem_addr,
  output logic [NEURON_WIDTH*LAYER_DATA_WIDTH-1:0] x_bus,
  output logic                                     act_func,
  input  logic [LAYER_DATA_WIDTH+7:0]              neuron_out,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [LAYER_DATA_WIDTH+7:0]              out_data,
  output logic [IDX_W-1:0]                         out_idx,
  output logic                                     busy,
  output logic                                     layer_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      x_bus    <= '0;
      act_func <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      // Vector and activation stay frozen for the whole pass; the neuron relies on it.
      if (state == S_IDLE && in_valid) begin
        x_bus    <= in_data;
        act_func <= in_act;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt = S_FETCH;
          idx_nxt   = '0;
        end
      end
      S_FETCH: state_nxt = abort ? S_IDLE : S_MAC;
      S_MAC:   state_nxt = abort ? S_IDLE : S_OUT;
      S_OUT: begin
        // abort beats a simultaneous final handshake, suppressing layer_done
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_FETCH;
            idx_nxt   = idx + IDX_W'(1);
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign wmem_rd_en = (state == S_FETCH);
  assign out_valid  = (state == S_OUT);
  assign layer_done = (state == S_DONE);
  assign wmem_addr  = idx;
  assign out_idx    = idx;
  assign out_data   = neuron_out;

endmodule
